lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  pipeline presents an access.
REQ-005 req_ready  out  1  high only in IDLE; a request is accepted on any edge where req_valid&req_ready.
REQ-006 req_we  in  1  1=store, 0=load.
REQ-007 req_memop  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use [1:0]: 00 sb, 01 sh, 10 sw.
REQ-008 req_addr  in  32  byte address; req_wdata  in  32  store data, right-justified.
REQ-009 resp_valid  out  1  one-cycle pulse on completion; resp_rdata out 32 load result (0 for stores); resp_err out 1 illegal memop; resp_split out 1 access was split into byte sub-accesses.
REQ-010 mem_addr out 32, mem_memop out 3, mem_we out 1, mem_datain out 32: drive the data-memory port.
REQ-011 mem_dataout  in  32  extended read data, valid the cycle after mem_addr/mem_memop are presented and held.

Function
REQ-012 SHALL latch req_we, req_memop, req_addr and req_wdata on acceptance; later changes on req_* are ignored until the next acceptance.
REQ-013 States: IDLE, ACC, RDW, RESP; IDLE->ACC on acceptance with a legal memop; IDLE->RESP with an illegal memop.
REQ-014 Illegal memop is a load with 011/110/111, or a store with [1:0]=11; it SHALL make no memory access and SHALL give resp_err=1 and resp_rdata=0.
REQ-015 Aligned means byte (any addr), halfword with addr[0]=0, or word with addr[1:0]=00; an aligned access is one sub-access with mem_addr=addr, mem_memop=memop and mem_datain=wdata.
REQ-016 Misaligned means a halfword with addr[0]=1 or a word with addr[1:0]!=00; it is N byte sub-accesses (N=2 halfword, 4 word), for i=0..N-1 in ascending order.
REQ-017 Byte sub-access i: mem_addr=addr+i (mod 2^32); mem_memop=000 for a store or 100 for a load; mem_datain={24'b0, wdata[8i+7:8i]}.
REQ-018 ACC: drives the current sub-access; for a store mem_we=1 for exactly this cycle, then ACC (next i) or RESP after the last; for a load mem_we=0, then RDW.
REQ-019 RDW: holds the mem_* outputs from ACC; for an aligned access captures mem_dataout whole; for a split access captures mem_dataout[7:0] into assembly byte i; then ACC (next i) or RESP after the last.
REQ-020 Split-load result is the little-endian assembly; lh sign-extends from bit 15, lhu zero-extends from bit 15, lw is unmodified.
REQ-021 RESP: resp_valid=1 for one cycle with resp_rdata, resp_err and resp_split stable; then IDLE.
REQ-022 mem_we SHALL be 0 in every state except ACC with a store.
REQ-023 Latency from the acceptance edge to resp_valid SHALL be: aligned store 2 cycles, aligned load 3, split halfword store 3, split word store 5, split halfword load 5, split word load 9, illegal 1.
REQ-024 Back-to-back: the next request SHALL be accepted in the cycle after RESP (IDLE), never during RESP.

Reset
REQ-025 While rst=1 at an edge, the state SHALL become IDLE, regardless of current state, and any in-flight access is discarded with no resp_valid.
REQ-026 After reset: req_ready=1, resp_valid=0, resp_err=0, resp_split=0, resp_rdata=0, mem_we=0, mem_addr=0, mem_memop=0, mem_datain=0.
REQ-027 Reset asserted during a split store SHALL suppress all remaining byte writes; bytes already written stay written.

Structure
REQ-028 Package lsu_pkg SHALL hold the memop encodings (LB..LHU, SB/SH/SW) and the state enumeration, shared with the pipeline and the memory controller.
REQ-029 A sub-module lsu_load_ext SHALL implement the combinational extension of REQ-020; all other logic stays in lsu_ctrl.

Verification
REQ-030 Preload word 0x100=0x8899AABB; lw @0x100 -> resp_rdata=0x8899AABB, resp_split=0, resp_valid 3 cycles after accept.
REQ-031 Preload 0x100=0x44332211, 0x104=0x88776655; lw @0x103 -> 4 lbu at 0x103..0x106, resp_rdata=0x77665544, resp_split=1, 9-cycle latency.
REQ-032 sh 0xBEEF @0x0FF, memory pre-zeroed -> two sb writes: byte 0x0FF=0xEF, byte 0x100=0xBE; lh @0x0FF -> 0xFFFFBEEF; lhu -> 0x0000BEEF.
REQ-033 Load with memop=011 -> resp_err=1, resp_rdata=0, no mem_we and no sub-access, resp_valid 1 cycle after accept.
REQ-034 sw 0xDDCCBBAA @0x201, rst pulsed the cycle after the 2nd sb write -> only 0x201=0xAA and 0x202=0xBB written, no resp_valid, req_ready=1 after reset.
REQ-035 Two back-to-back sb requests with req_valid held high -> second accepted in the cycle after the first RESP, mem_we pulses exactly once per store.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared load/store definitions: memop encodings, controller states and
// the small decode helpers used by the LSU controller.
package lsu_pkg;

   localparam logic [2:0] MEMOP_LB  = 3'b000;
   localparam logic [2:0] MEMOP_LH  = 3'b001;
   localparam logic [2:0] MEMOP_LW  = 3'b010;
   localparam logic [2:0] MEMOP_LBU = 3'b100;
   localparam logic [2:0] MEMOP_LHU = 3'b101;

   localparam logic [1:0] MEMOP_SB = 2'b00;
   localparam logic [1:0] MEMOP_SH = 2'b01;
   localparam logic [1:0] MEMOP_SW = 2'b10;

   typedef enum logic [1:0] {IDLE, ACC, RDW, RESP} lsu_state_t;

   function automatic logic memop_illegal(input logic we, input logic [2:0] memop);
      if (we) return memop[1:0] == 2'b11;
      return memop inside {3'b011, 3'b110, 3'b111};
   endfunction

   // Size is carried in memop[1:0] for both loads and stores.
   function automatic logic misaligned(input logic [2:0] memop, input logic [1:0] addr_lo);
      return (memop[1:0] == MEMOP_SH && addr_lo[0]) ||
             (memop[1:0] == MEMOP_SW && addr_lo != 2'b00);
   endfunction

   function automatic logic [1:0] last_byte(input logic [2:0] memop);
      return (memop[1:0] == MEMOP_SW) ? 2'd3 : 2'd1;
   endfunction

   function automatic logic [31:0] byte_lane(input logic [31:0] w, input logic [1:0] i);
      case (i)
         2'd0:    return {24'b0, w[7:0]};
         2'd1:    return {24'b0, w[15:8]};
         2'd2:    return {24'b0, w[23:16]};
         default: return {24'b0, w[31:24]};
      endcase
   endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Sign/zero extension of an assembled little-endian load value.
module lsu_load_ext
   import lsu_pkg::*;
(
   input  logic [2:0]  memop,
   input  logic [31:0] raw,
   output logic [31:0] data
);

   always_comb begin
      // NOTE: default assignment first so every path drives data; no latch is inferred.
      data = raw;
      case (memop)
         MEMOP_LB:  data = {{24{raw[7]}}, raw[7:0]};
         MEMOP_LBU: data = {24'b0, raw[7:0]};
         MEMOP_LH:  data = {{16{raw[15]}}, raw[15:0]};
         MEMOP_LHU: data = {16'b0, raw[15:0]};
         default:   data = raw;
      endcase
   end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one access at a time, splits misaligned
// halfword/word accesses into ascending byte sub-accesses and reports completion.
module lsu_ctrl
   import lsu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_memop,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        resp_split,
   output logic [31:0] mem_addr,
   output logic [2:0]  mem_memop,
   output logic        mem_we,
   output logic [31:0] mem_datain,
   input  logic [31:0] mem_dataout
);

   lsu_state_t  state;
   logic        we_q;
   logic [2:0]  memop_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic        split_q;
   logic [1:0]  idx_q;
   logic [1:0]  last_q;
   logic [31:0] asm_q;
   logic [31:0] asm_next;
   logic [31:0] ext_data;
   logic [1:0]  next_idx;
   logic        last;
   logic        req_mis;

   assign next_idx = idx_q + 2'd1;
   assign last     = (idx_q == last_q);
   assign req_mis  = misaligned(req_memop, req_addr[1:0]);

   // Merge the byte arriving this cycle so the final byte is visible to the extender.
   always_comb begin
      asm_next = asm_q;
      asm_next[{idx_q, 3'b000} +: 8] = mem_dataout[7:0];
   end

   lsu_load_ext u_load_ext (
      .memop (memop_q),
      .raw   (asm_next),
      .data  (ext_data)
   );

   // NOTE: all state and registered outputs use non-blocking assignments.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         resp_split <= 1'b0;
         mem_addr   <= '0;
         mem_memop  <= '0;
         mem_we     <= 1'b0;
         mem_datain <= '0;
         we_q       <= 1'b0;
         memop_q    <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         split_q    <= 1'b0;
         idx_q      <= '0;
         last_q     <= '0;
         asm_q      <= '0;
      end else begin
         resp_valid <= 1'b0;
         mem_we     <= 1'b0;
         case (state)
            IDLE: if (req_valid) begin
               we_q      <= req_we;
               memop_q   <= req_memop;
               addr_q    <= req_addr;
               wdata_q   <= req_wdata;
               req_ready <= 1'b0;
               if (memop_illegal(req_we, req_memop)) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b1;
                  resp_rdata <= '0;
                  resp_split <= 1'b0;
               end else begin
                  state    <= ACC;
                  split_q  <= req_mis;
                  idx_q    <= 2'd0;
                  last_q   <= req_mis ? last_byte(req_memop) : 2'd0;
                  asm_q    <= '0;
                  mem_addr <= req_addr;
                  mem_we   <= req_we;
                  if (req_mis) begin
                     mem_memop  <= req_we ? {1'b0, MEMOP_SB} : MEMOP_LBU;
                     mem_datain <= byte_lane(req_wdata, 2'd0);
                  end else begin
                     mem_memop  <= req_memop;
                     mem_datain <= req_wdata;
                  end
               end
            end
            ACC: begin
               if (!we_q) begin
                  state <= RDW;
               end else if (last) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_rdata <= '0;
                  resp_split <= split_q;
               end else begin
                  idx_q      <= next_idx;
                  mem_addr   <= addr_q + {30'b0, next_idx};
                  mem_datain <= byte_lane(wdata_q, next_idx);
                  mem_we     <= 1'b1;
               end
            end
            RDW: begin
               if (!split_q || last) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
                  resp_err   <= 1'b0;
                  resp_split <= split_q;
                  resp_rdata <= split_q ? ext_data : mem_dataout;
               end else begin
                  state      <= ACC;
                  idx_q      <= next_idx;
                  mem_addr   <= addr_q + {30'b0, next_idx};
                  mem_datain <= byte_lane(wdata_q, next_idx);
               end
               if (split_q) asm_q <= asm_next;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: byte-array memory device, a transaction-level
// model of expected writes/responses/latency, and directed scenarios.
module tb_lsu_ctrl;
   import lsu_pkg::*;

   logic        clk, rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_memop;
   logic [31:0] req_addr, req_wdata;
   logic        resp_valid, resp_err, resp_split;
   logic [31:0] resp_rdata;
   logic [31:0] mem_addr, mem_datain, mem_dataout;
   logic [2:0]  mem_memop;
   logic        mem_we;

   lsu_ctrl dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_memop(req_memop), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .resp_split(resp_split),
      .mem_addr(mem_addr), .mem_memop(mem_memop), .mem_we(mem_we),
      .mem_datain(mem_datain), .mem_dataout(mem_dataout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int n_writes = 0;

   typedef struct {logic [31:0] addr; logic [2:0] memop; logic [31:0] data;} wr_t;
   typedef struct {logic err; logic [31:0] rdata; logic split;} rsp_t;
   wr_t exp_wr[$];
   rsp_t exp_rsp[$];

   logic [7:0] dmem    [logic [31:0]];
   logic [7:0] ref_mem [logic [31:0]];

   logic [31:0] got_rdata;
   logic        got_err, got_split;
   int          got_lat;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] dbyte(input logic [31:0] a);
      return dmem.exists(a) ? dmem[a] : 8'h00;
   endfunction

   function automatic logic [7:0] rbyte(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   function automatic logic [31:0] extend(input logic [2:0] memop, input logic [31:0] raw);
      case (memop)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b100:  return {24'b0, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b101:  return {16'b0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   // Data memory device: writes on the edge, extended read data one cycle later.
   always @(posedge clk) begin
      logic [31:0] raw;
      int n;
      if (mem_we) begin
         n = (mem_memop[1:0] == 2'b00) ? 1 : (mem_memop[1:0] == 2'b01) ? 2 : 4;
         for (int k = 0; k < n; k++) dmem[mem_addr + 32'(k)] = mem_datain[8*k +: 8];
      end
      raw = {dbyte(mem_addr + 32'd3), dbyte(mem_addr + 32'd2),
             dbyte(mem_addr + 32'd1), dbyte(mem_addr)};
      mem_dataout <= extend(mem_memop, raw);
   end

   // Compare process: every write and every response against the model's queues.
   always @(negedge clk) begin
      wr_t w;
      rsp_t r;
      if (mem_we === 1'b1) begin
         n_writes++;
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h, required none", mem_addr, mem_datain);
         end else begin
            w = exp_wr.pop_front();
            check("wr_addr", mem_addr, w.addr);
            check("wr_memop", {29'b0, mem_memop}, {29'b0, w.memop});
            check("wr_data", mem_datain, w.data);
         end
      end
      if (resp_valid === 1'b1) begin
         if (exp_rsp.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp: got rdata 0x%08h, required no response", resp_rdata);
         end else begin
            r = exp_rsp.pop_front();
            check("resp_rdata", resp_rdata, r.rdata);
            check("resp_err", {31'b0, resp_err}, {31'b0, r.err});
            check("resp_split", {31'b0, resp_split}, {31'b0, r.split});
         end
      end
   end

   task automatic preload(input logic [31:0] a, input logic [31:0] d);
      for (int k = 0; k < 4; k++) begin
         dmem[a + 32'(k)]    = d[8*k +: 8];
         ref_mem[a + 32'(k)] = d[8*k +: 8];
      end
   endtask

   // Model the access, queue its expectations, then present it until accepted.
   task automatic issue(input logic we, input logic [2:0] memop, input logic [31:0] addr,
                        input logic [31:0] wdata, input bit keep_valid,
                        output int exp_lat, output int waited);
      bit illegal, mis;
      int size;
      rsp_t r;
      wr_t w;
      illegal = we ? (memop[1:0] == 2'b11) : (memop == 3'b011 || memop == 3'b110 || memop == 3'b111);
      size = (memop[1:0] == 2'b00) ? 1 : (memop[1:0] == 2'b01) ? 2 : 4;
      mis = !illegal && ((size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0));
      r.err = illegal;
      r.split = mis;
      r.rdata = '0;
      if (!illegal && !we)
         r.rdata = extend(memop, {rbyte(addr + 32'd3), rbyte(addr + 32'd2), rbyte(addr + 32'd1), rbyte(addr)});
      if (!illegal && we) begin
         if (mis) begin
            for (int k = 0; k < size; k++) begin
               w.addr = addr + 32'(k); w.memop = 3'b000; w.data = {24'b0, wdata[8*k +: 8]};
               exp_wr.push_back(w);
            end
         end else begin
            w.addr = addr; w.memop = memop; w.data = wdata;
            exp_wr.push_back(w);
         end
         for (int k = 0; k < size; k++) ref_mem[addr + 32'(k)] = wdata[8*k +: 8];
      end
      exp_rsp.push_back(r);
      exp_lat = illegal ? 1 : we ? (mis ? size + 1 : 2) : (mis ? 2 * size + 1 : 3);

      @(negedge clk);
      req_we = we; req_memop = memop; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
      waited = 0;
      while (req_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      if (req_ready !== 1'b1) begin
         checks++; errors++;
         $display("FAIL accept_timeout: req_ready still %b after %0d cycles", req_ready, waited);
      end
      @(posedge clk);
      #1;
      if (!keep_valid) begin
         // Scramble the request lines: the access must already be latched.
         req_valid = 1'b0; req_we = ~we; req_memop = 3'b111; req_addr = ~addr; req_wdata = ~wdata;
      end
   endtask

   task automatic wait_resp(input string name, input int exp_lat);
      int lat;
      for (lat = 1; lat <= 40; lat++) begin
         @(negedge clk);
         if (resp_valid === 1'b1) break;
      end
      got_lat = lat; got_rdata = resp_rdata; got_err = resp_err; got_split = resp_split;
      check({name, "_lat"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic run(input string name, input logic we, input logic [2:0] memop,
                      input logic [31:0] addr, input logic [31:0] wdata);
      int lat, waited;
      issue(we, memop, addr, wdata, 1'b0, lat, waited);
      wait_resp(name, lat);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},  {31'b0, req_ready},  32'd1);
      check({tag, "_resp_valid"}, {31'b0, resp_valid}, 32'd0);
      check({tag, "_resp_err"},   {31'b0, resp_err},   32'd0);
      check({tag, "_resp_split"}, {31'b0, resp_split}, 32'd0);
      check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
      check({tag, "_mem_we"},     {31'b0, mem_we},     32'd0);
      check({tag, "_mem_addr"},   mem_addr, 32'd0);
      check({tag, "_mem_memop"},  {29'b0, mem_memop},  32'd0);
      check({tag, "_mem_datain"}, mem_datain, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int lat, waited, wr_before;
      bit found;
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_memop = '0; req_addr = '0; req_wdata = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      // Aligned word load.
      preload(32'h100, 32'h8899AABB);
      run("lw_aligned", 1'b0, MEMOP_LW, 32'h100, 32'h0);
      check("lw_aligned_lit", got_rdata, 32'h8899AABB);
      check("lw_aligned_lat_lit", 32'(got_lat), 32'd3);
      check("lw_aligned_split_lit", {31'b0, got_split}, 32'd0);

      // Misaligned word load assembled from four byte reads.
      preload(32'h100, 32'h44332211);
      preload(32'h104, 32'h88776655);
      run("lw_split", 1'b0, MEMOP_LW, 32'h103, 32'h0);
      check("lw_split_lit", got_rdata, 32'h77665544);
      check("lw_split_lat_lit", 32'(got_lat), 32'd9);
      check("lw_split_split_lit", {31'b0, got_split}, 32'd1);

      // Misaligned halfword store across a word boundary, then read back both ways.
      preload(32'h0FC, 32'h0);
      preload(32'h100, 32'h0);
      run("sh_split", 1'b1, {1'b0, MEMOP_SH}, 32'h0FF, 32'h0000BEEF);
      check("sh_split_lat_lit", 32'(got_lat), 32'd3);
      check("sh_byte_0ff_lit", {24'b0, dbyte(32'h0FF)}, 32'h0000_00EF);
      check("sh_byte_100_lit", {24'b0, dbyte(32'h100)}, 32'h0000_00BE);
      run("lh_split", 1'b0, MEMOP_LH, 32'h0FF, 32'h0);
      check("lh_split_lit", got_rdata, 32'hFFFFBEEF);
      check("lh_split_lat_lit", 32'(got_lat), 32'd5);
      run("lhu_split", 1'b0, MEMOP_LHU, 32'h0FF, 32'h0);
      check("lhu_split_lit", got_rdata, 32'h0000BEEF);

      // Illegal memops: no memory access, error response after one cycle.
      run("illegal_load", 1'b0, 3'b011, 32'h100, 32'h0);
      check("illegal_load_err_lit", {31'b0, got_err}, 32'd1);
      check("illegal_load_lat_lit", 32'(got_lat), 32'd1);
      run("illegal_store", 1'b1, 3'b111, 32'h100, 32'h12345678);

      // Aligned store plus aligned/split loads with sign and zero extension.
      run("sw_aligned", 1'b1, {1'b0, MEMOP_SW}, 32'h300, 32'h12F45678);
      check("sw_aligned_lat_lit", 32'(got_lat), 32'd2);
      run("lb_aligned", 1'b0, MEMOP_LB, 32'h302, 32'h0);
      check("lb_aligned_lit", got_rdata, 32'hFFFFFFF4);
      run("lbu_aligned", 1'b0, MEMOP_LBU, 32'h302, 32'h0);
      run("lhu_aligned", 1'b0, MEMOP_LHU, 32'h302, 32'h0);
      run("lh_split2", 1'b0, MEMOP_LH, 32'h301, 32'h0);
      check("lh_split2_lit", got_rdata, 32'hFFFFF456);
      run("sb_aligned", 1'b1, {1'b0, MEMOP_SB}, 32'h303, 32'h000000A7);
      run("lw_after_sb", 1'b0, MEMOP_LW, 32'h300, 32'h0);

      // Address wrap at the top of memory and a misaligned word store/load.
      run("sh_wrap", 1'b1, {1'b0, MEMOP_SH}, 32'hFFFFFFFF, 32'h0000A55A);
      run("lhu_wrap", 1'b0, MEMOP_LHU, 32'hFFFFFFFF, 32'h0);
      check("lhu_wrap_lit", got_rdata, 32'h0000A55A);
      run("sw_split", 1'b1, {1'b0, MEMOP_SW}, 32'h402, 32'hCAFEF00D);
      check("sw_split_lat_lit", 32'(got_lat), 32'd5);
      run("lw_split2", 1'b0, MEMOP_LW, 32'h402, 32'h0);
      check("lw_split2_lit", got_rdata, 32'hCAFEF00D);

      // Reset during a split word store after the second byte write.
      preload(32'h200, 32'h0);
      preload(32'h204, 32'h0);
      issue(1'b1, {1'b0, MEMOP_SW}, 32'h201, 32'hDDCCBBAA, 1'b0, lat, waited);
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
         @(negedge clk);
         if (mem_we === 1'b1 && mem_addr == 32'h202) found = 1'b1;
      end
      check("rst_split_found_2nd_write", {31'b0, found}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_wr.delete();
      exp_rsp.delete();
      ref_mem[32'h203] = 8'h00;
      ref_mem[32'h204] = 8'h00;
      check_reset_outputs("rst_split");
      repeat (12) @(negedge clk);
      check("rst_byte_201", {24'b0, dbyte(32'h201)}, 32'h0000_00AA);
      check("rst_byte_202", {24'b0, dbyte(32'h202)}, 32'h0000_00BB);
      check("rst_byte_203", {24'b0, dbyte(32'h203)}, 32'h0);
      check("rst_byte_204", {24'b0, dbyte(32'h204)}, 32'h0);

      // Back-to-back stores with req_valid held high.
      wr_before = n_writes;
      issue(1'b1, {1'b0, MEMOP_SB}, 32'h500, 32'h00000011, 1'b1, lat, waited);
      req_addr = 32'h501; req_wdata = 32'h00000022;
      wait_resp("b2b_first", lat);
      check("b2b_ready_in_resp", {31'b0, req_ready}, 32'd0);
      issue(1'b1, {1'b0, MEMOP_SB}, 32'h501, 32'h00000022, 1'b0, lat, waited);
      check("b2b_accept_wait", 32'(waited), 32'd0);
      wait_resp("b2b_second", lat);
      repeat (3) @(negedge clk);
      check("b2b_write_count", 32'(n_writes - wr_before), 32'd2);
      check("b2b_byte_500", {24'b0, dbyte(32'h500)}, 32'h0000_0011);
      check("b2b_byte_501", {24'b0, dbyte(32'h501)}, 32'h0000_0022);

      check("pending_writes", 32'(exp_wr.size()), 32'd0);
      check("pending_resps", 32'(exp_rsp.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
